// File: rtl/t_flipflop_ip_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t_flipflop_ip_pkg
// Brief    : Shared limits and next-state helper for the toggle flip-flop IP.
// Revision : 1.0 - initial release
// ============================================================================
package t_flipflop_ip_pkg;

    localparam int c_MIN_WIDTH = 1;
    localparam int c_MAX_WIDTH = 64;

    // Reset dominates toggle; a zero toggle enable holds the bit.
    function automatic logic ff_next(input logic q, input logic t,
                                     input logic rst, input logic rv);
        return rst ? rv : (q ^ t);
    endfunction

endpackage : t_flipflop_ip_pkg
`default_nettype wire

// File: rtl/t_flipflop_ip_cell.sv
`default_nettype none
// ============================================================================
// Module   : t_ff_cell
// Brief    : Single toggle flip-flop bit with synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module t_ff_cell
    import t_flipflop_ip_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    // Declaration initialiser gives a defined power-up value before any reset.
    logic r_state_q = RESET_VALUE;
    logic w_state_d;

    always_comb begin
        w_state_d = ff_next(r_state_q, t, rst, RESET_VALUE);
    end

    always_ff @(posedge clk) begin
        r_state_q <= w_state_d;
    end

    assign q = r_state_q;

endmodule : t_ff_cell
`default_nettype wire

// File: rtl/t_flipflop_ip.sv
`default_nettype none
// ============================================================================
// Module   : t_flipflop_ip
// Brief    : WIDTH independent toggle flip-flops, one cell per bit.
// Revision : 1.0 - initial release
// ============================================================================
module t_flipflop_ip
    import t_flipflop_ip_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    // Each bit is its own register, so no carry can couple neighbouring bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        t_ff_cell #(
            .RESET_VALUE (RESET_VALUE[gi])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[gi]),
            .q   (q[gi])
        );
    end

endmodule : t_flipflop_ip
`default_nettype wire

// File: tb/tb_t_flipflop_ip.sv
`default_nettype none
// ============================================================================
// Module   : tb_t_flipflop_ip
// Brief    : Scoreboard bench for t_flipflop_ip at WIDTH=1 and WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t_flipflop_ip;

    localparam logic [3:0] c_RV4 = 4'b1010;

    typedef struct packed {
        logic       e1;
        logic [3:0] e4;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] t1  = '0;
    logic [3:0] t4  = '0;
    logic [0:0] q1;
    logic [3:0] q4;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Reference state: what each register should hold after the latest edge.
    logic       m1 = 1'b0;
    logic [3:0] m4 = c_RV4;

    t_flipflop_ip u_dut1 (
        .clk (clk),
        .rst (rst),
        .t   (t1),
        .q   (q1)
    );

    t_flipflop_ip #(
        .WIDTH       (4),
        .RESET_VALUE (c_RV4)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .t   (t4),
        .q   (q4)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // One clock: drive at the falling edge, optionally glitch between edges,
    // then record what the next rising edge must produce.
    task automatic step(input logic r, input logic tv1, input logic [3:0] tv4,
                        input bit glitch);
        exp_t e;
        @(negedge clk);
        rst = r;
        t1  = tv1;
        t4  = tv4;
        if (glitch) begin
            #1 rst = 1'b1; t1 = ~tv1; t4 = ~tv4;
            #1 rst = 1'b0; t1 = tv1;  t4 = tv4;
            #1;
            check1("glitch_hold_q1", q1[0], m1);
            check4("glitch_hold_q4", q4, m4);
            rst = r;
        end
        if (r) begin
            m1 = 1'b0;
            m4 = c_RV4;
        end else begin
            m1 = m1 ^ tv1;
            m4 = m4 ^ tv4;
        end
        e.e1 = m1;
        e.e4 = m4;
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: the outputs are valid every cycle, just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check1("q1", q1[0], e.e1);
            check4("q4", q4, e.e4);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check1("powerup_q1", q1[0], 1'b0);
        check4("powerup_q4", q4, c_RV4);

        // Reset then hold with t=0.
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0);

        // Two toggles then hold.
        step(1'b0, 1'b1, 4'b0011, 1'b0);
        #2 check4("req027_q4", q4, 4'b1001);
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0);

        // Reach q=1, then reset and toggle together, held for 3 edges.
        step(1'b0, 1'b1, 4'b1111, 1'b0);
        #2 check1("pre_reset_q1", q1[0], 1'b1);
        repeat (3) step(1'b1, 1'b1, 4'b1111, 1'b0);
        #2 check1("reset_wins_q1", q1[0], 1'b0);

        // Release reset with t held high: square wave from the first free edge.
        repeat (4) step(1'b0, 1'b1, 4'b0101, 1'b0);

        // Between-edge glitches on rst and t must not disturb q.
        repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b1, 4'b1000, 1'b1);

        // Randomised traffic, with occasional resets and glitches.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom),
                 ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_t_flipflop_ip
`default_nettype wire
